// File: rtl/weight_rom_stream_reader.sv
// Streaming weight reader: issues sequential ROM addresses, tracks reads through the
// fixed-latency ROM pipeline and buffers returned words in a small credit-limited FIFO.

module weight_rom_stream_reader_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          push_i,
  input logic [CW-1:0] count_i
);

  // A returning read must always find a free slot; a full-FIFO push means the credit logic broke.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push_i && (count_i == CW'(FIFO_DEPTH))));

endmodule

module weight_rom_stream_reader #(
  parameter int DEPTH        = 32,
  parameter int PRECISION    = 16,
  parameter int LANES        = 1,
  parameter int ROM_WIDTH    = PRECISION * LANES,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2,
  parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [ADDR_WIDTH-1:0]           rom_addr,
  output logic                            rom_ce,
  input  logic [ROM_WIDTH-1:0]            rom_q,
  output logic [LANES-1:0][PRECISION-1:0] data_out,
  output logic                            data_out_valid,
  input  logic                            data_out_ready,
  output logic                            data_out_last
);

  localparam int DW = PRECISION * LANES;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW = CW + 1;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } entry_t;

  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [READ_LATENCY-1:0] infl_q, infl_d;
  logic [READ_LATENCY-1:0] lflag_q, lflag_d;
  logic [CW-1:0]           infl_cnt_q, infl_cnt_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  entry_t                  mem_q [FIFO_DEPTH];

  logic   issue_s;
  logic   push_s;
  logic   pop_s;
  logic   addr_last_s;
  entry_t wdata_s;
  entry_t head_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

  // In-flight reads are counted as occupied credits, so a return always has room.
  assign issue_s     = (SW'(count_q) + SW'(infl_cnt_q)) < SW'(FIFO_DEPTH);
  assign push_s      = infl_q[READ_LATENCY-1];
  assign pop_s       = data_out_valid && data_out_ready;
  assign addr_last_s = (addr_q == ADDR_WIDTH'(DEPTH - 1));
  assign wdata_s     = '{last: lflag_q[READ_LATENCY-1], data: rom_q[DW-1:0]};
  assign head_s      = mem_q[rd_ptr_q];

  // Enable must already be high in the first cycle after release so address 0 is sampled then.
  assign rom_ce         = rst;
  assign rom_addr       = addr_q;
  assign data_out_valid = (count_q != CW'(0));
  assign data_out       = head_s.data;
  assign data_out_last  = head_s.last;

  // Next-state for address, read-tracking pipeline, counters and pointers.
  always_comb begin
    addr_d     = addr_q;
    infl_d     = (infl_q << 1) | READ_LATENCY'(issue_s);
    lflag_d    = (lflag_q << 1) | READ_LATENCY'(issue_s && addr_last_s);
    infl_cnt_d = infl_cnt_q + CW'(issue_s) - CW'(push_s);
    count_d    = count_q + CW'(push_s) - CW'(pop_s);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (issue_s) begin
      if (addr_last_s) begin
        addr_d = ADDR_WIDTH'(0);
      end else begin
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end else begin
      addr_d = addr_q;
    end

    if (push_s) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= ADDR_WIDTH'(0);
      infl_q     <= READ_LATENCY'(0);
      lflag_q    <= READ_LATENCY'(0);
      infl_cnt_q <= CW'(0);
      count_q    <= CW'(0);
      wr_ptr_q   <= PW'(0);
      rd_ptr_q   <= PW'(0);
    end else begin
      addr_q     <= addr_d;
      infl_q     <= infl_d;
      lflag_q    <= lflag_d;
      infl_cnt_q <= infl_cnt_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer storage; cleared on reset so the head entry is never X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

  weight_rom_stream_reader_chk #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CW        (CW)
  ) u_chk (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push_s),
    .count_i(count_q)
  );

endmodule

// File: doc/weight_rom_stream_reader.md
# weight_rom_stream_reader

Latency-aware streaming reader placed between a parameter ROM and the linear layer that consumes its weights. It issues sequential ROM addresses, tracks reads in flight through the ROM's fixed read pipeline, and buffers the returned words in a small FIFO. The consumer gets a true valid/ready stream with no data loss under backpressure, plus a last-vector marker. It replaces the free-running "valid always high" weight source path.

## Interface
- DEPTH, 32: number of weight vectors per pass; the address range is 0..DEPTH-1.
- PRECISION, 16: bits per weight lane.
- LANES, 1: lanes per output beat.
- ROM_WIDTH, PRECISION*LANES: width of `rom_q`; must be ≥ PRECISION*LANES. Only the low PRECISION*LANES bits are used.
- READ_LATENCY, 2: rising edges from address sample to `rom_q` valid. Legal range 1..4.
- FIFO_DEPTH, READ_LATENCY+2: output buffer entries. Values below READ_LATENCY+2 are legal but reduce throughput.
- ADDR_WIDTH, $clog2(DEPTH)+1: width of `rom_addr`.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rom_addr  out  ADDR_WIDTH  address to the ROM.
- rom_ce  out  1  ROM clock enable.
- rom_q  in  ROM_WIDTH  ROM read data.
- data_out  out  PRECISION x [LANES]  lane j = `rom_q[PRECISION*j +: PRECISION]` of the head entry.
- data_out_valid  out  1  FIFO non-empty.
- data_out_ready  in  1  consumer accepts the current beat.
- data_out_last  out  1  head entry came from address DEPTH-1.

## Operation
- Reset (rst=0) clears all state immediately, regardless of clock:
  - `rom_addr`=0, `rom_ce`=0, `data_out_valid`=0, `data_out_last`=0, `data_out`=0.
  - FIFO empty, in-flight shift register cleared.
- Once out of reset, `rom_ce` is 1 every cycle, so the ROM pipeline always advances and return timing is fixed.
- Issue condition (evaluated each cycle): `fifo_count + inflight_count < FIFO_DEPTH`. Both counts are registered values; a same-cycle pop is not credited.
- On issue:
  - The ROM samples `rom_addr` at the closing edge.
  - A 1 enters bit 0 of an in-flight shift register of length READ_LATENCY. A parallel shift register carries the flag "addr == DEPTH-1".
  - `rom_addr` advances: DEPTH-1 wraps to 0, otherwise +1.
- On no-issue: `rom_addr` holds, and a 0 enters the shift register.
- Return: when the shift register's MSB is 1, {`rom_q` lanes, last flag} is written to the FIFO tail at that edge.
- Pop: occurs when `data_out_valid` && `data_out_ready`; head advances.
- Push and pop in the same cycle are both performed and `fifo_count` is unchanged.
- Overflow is impossible by construction. A push into a full FIFO is a design error and must be flagged by an assertion.
- `inflight_count` = popcount of the shift register, held as a counter: +issue, -return.
- FIFO is a circular buffer with wrapping read/write pointers and a count of width $clog2(FIFO_DEPTH+1).
- `data_out` and `data_out_last` are driven from the head entry. When the FIFO is empty they are don't-care, but must not be X after reset.

## Timing
- First issue occurs in cycle 0, the first cycle with rst=1. Address 0 is sampled at the end of cycle 0.
- `rom_q` for address 0 is present in cycle READ_LATENCY and written at the end of that cycle.
- `data_out_valid` first rises in cycle READ_LATENCY+1 (cycle 3 at default).
- Throughput: one beat per cycle sustained when `data_out_ready` is held 1 and FIFO_DEPTH ≥ READ_LATENCY+2.
- Under backpressure, `data_out` and `data_out_last` stay stable while valid && !ready.
- Issue stops once occupancy reaches FIFO_DEPTH. At most FIFO_DEPTH beats are buffered.
- Recovery: after ready returns to 1, the first freed credit re-enables issue on the following cycle. No bubble-free guarantee applies during refill.
- Reset asserted mid-stream discards FIFO contents and in-flight reads. Stale `rom_q` returning after reset release is ignored because the shift register was cleared. The stream restarts at address 0.

## Test plan
- Reset values: hold rst=0 with random `rom_q` -> all outputs 0, `rom_ce`=0. Release -> `rom_addr` sequence 0,1,2… and first valid exactly in cycle 3.
- Full-rate stream: DEPTH=8, LANES=2, PRECISION=16, ROM word[a] = {a+100, a} per lane, ready=1 for 20 beats -> beats in order 0..7,0..7,0..3. `data_out_last`=1 only on beats 7 and 15. No idle cycles after the first valid.
- Backpressure: ready=0 for 10 cycles starting at beat 2 -> data frozen at beat 2. `fifo_count` peaks at 4 and no further issues occur. After ready=1, beats continue 3,4,… with none lost or duplicated.
- Random ready (50%) for 500 beats -> the output sequence equals the address modulo DEPTH. The assertion never fires.
- Async reset mid-stream: assert rst=0 mid-cycle at beat 5 -> outputs clear before the next edge. After release, the stream restarts at value 0 with no stale beat.
- READ_LATENCY=1, FIFO_DEPTH=3 -> first valid in cycle 2. Full rate is sustained.
